dzcpu_uop_sequencer: RTL and testbench
======================================

DZCPU_UOP_SEQUENCER -- requirements
Module: dzcpu_uop_sequencer

Interface
REQ-001 The parameter JCB_OP SHALL default to 5'h1F and SHALL be the operation-field code that triggers a 0xCB table jump.
REQ-002 The port iClock SHALL be an input, 1 bit wide, and SHALL be the single clock; every register updates on its rising edge.
REQ-003 The port iReset SHALL be an input, 1 bit wide; it SHALL be an asynchronous, active-low reset.
REQ-004 The port iMop SHALL be an input, 8 bits wide, carrying the memory read data (opcode byte).
REQ-005 The port iMopValid SHALL be an input, 1 bit wide, qualifying iMop.
REQ-006 The port iStall SHALL be an input, 1 bit wide; while high, all sequencer state holds.
REQ-007 The port iZ SHALL be an input, 1 bit wide, carrying the datapath zero flag.
REQ-008 The port iFlowIdx SHALL be an input, 8 bits wide, returned by the main opcode LUT for oMop.
REQ-009 The port iCbFlowIdx SHALL be an input, 8 bits wide, returned by the CB-prefix LUT for oMop.
REQ-010 The port iUop SHALL be an input, 12 bits wide, returned by the ucode ROM for oUopAddr; its fields are [11:9] flow, [8:4] operation, [3:0] operand.
REQ-011 The port oMop SHALL be an output, 8 bits wide, driving the latched opcode to both LUTs.
REQ-012 The port oUopAddr SHALL be an output, 8 bits wide, driving the ROM address.
REQ-013 The port oUop SHALL be an output, 12 bits wide, carrying iUop passed through to the datapath.
REQ-014 The port oUopValid SHALL be an output, 1 bit wide, high when oUop is to be executed this cycle.
REQ-015 The port oPcInc SHALL be an output, 1 bit wide, a one-cycle PC increment pulse.
REQ-016 The port oRetire SHALL be an output, 1 bit wide, a one-cycle end-of-instruction pulse.
REQ-017 The port oIllegal SHALL be an output, 1 bit wide, flagging an unmapped CB opcode.

Function
REQ-018 The FSM SHALL have the states FETCH, DECODE, EXEC, CBDEC and TRAP; when iStall=1, no state, address or pulse SHALL change, and oPcInc, oRetire and oUopValid SHALL be held at 0.
REQ-019 In FETCH, when iMopValid=1, the block SHALL latch iMop into oMop and go to DECODE; otherwise it SHALL stay in FETCH.
REQ-020 In DECODE, the block SHALL load oUopAddr from iFlowIdx and go to EXEC; latency from the iMopValid sample to the first oUopValid SHALL be 2 cycles.
REQ-021 In EXEC, oUopValid SHALL be 1, and oUop SHALL equal iUop.
REQ-022 Flow decode in EXEC:
- 0 (op): oUopAddr+1.
- 1 (inc): oUopAddr+1 and oPcInc=1.
- 2 (eof): oRetire=1, then go to FETCH.
- 3 (inc_eof): oPcInc=1 and oRetire=1, then go to FETCH.
- 4 (inc_eof_z): oPcInc=1; if iZ=1 then oRetire=1 and go to FETCH, else oUopAddr+1.
- 5-7: treated as op.
REQ-023 When the operation field equals JCB_OP in EXEC, the flow-field pulses SHALL still apply, iMop SHALL be latched into oMop, and the next state SHALL be CBDEC regardless of the flow code.
REQ-024 In CBDEC, oUopAddr SHALL load from iCbFlowIdx, and the next state SHALL be EXEC.
REQ-025 oUopAddr increments SHALL wrap modulo 256 (255 goes to 0).
REQ-026 oUopValid, oPcInc and oRetire SHALL be 0 in every state other than EXEC.

Reset
REQ-027 While iReset=0, the state SHALL be FETCH, and oMop, oUopAddr, oUopValid, oPcInc, oRetire and oIllegal SHALL be 0.
REQ-028 A reset asserted mid-instruction SHALL abort the instruction with no oRetire, and fetch SHALL restart on the first edge after release.

Configuration
REQ-029 With DZCPU_CB_TRAP_EN defined, iCbFlowIdx=0 in CBDEC SHALL enter TRAP; TRAP SHALL set oIllegal=1 and hold until reset.
REQ-030 Without DZCPU_CB_TRAP_EN, iCbFlowIdx=0 SHALL be loaded like any other index, and oIllegal SHALL be tied to 0.

Verification
REQ-031 Opcode 0x00, with the LUT returning 0 and ROM[0] flow=3: the bench SHALL see oUopValid 2 cycles after the iMopValid sample, then oPcInc=1 and oRetire=1 in the same cycle, then FETCH.
REQ-032 Opcode 0x31, with the LUT returning 1 and ROM[1..4] flows inc, inc, op, inc_eof: the bench SHALL see oUopAddr 1,2,3,4, three oPcInc pulses, and one oRetire.
REQ-033 The ROM[13..15] CB flow (inc/op/inc+JCB_OP) with iMop=0x7C and the CB LUT returning 16: the bench SHALL see oMop=0x7C, then oUopAddr=16, then the eof at ROM[16] giving oRetire.
REQ-034 The inc_eof_z uop at address 19: with iZ=1 the bench SHALL see retire at 19; with iZ=0 it SHALL see oUopAddr=20 and no oRetire.
REQ-035 Stall and reset: iStall=1 for 3 cycles in EXEC at address 6 SHALL hold oUopAddr=6 with no pulses; iReset=0 at address 7 SHALL clear all outputs asynchronously.
REQ-036 With DZCPU_CB_TRAP_EN defined and the CB LUT returning 0: the bench SHALL see oIllegal=1, held until reset; without the macro it SHALL see oUopAddr=0 in EXEC.

Source files
------------

// File: rtl/dzcpu_uop_sequencer.sv
// dzcpu micro-op sequencer: opcode fetch, LUT decode, ucode ROM walk, 0xCB prefix.
// Define DZCPU_CB_TRAP_EN to trap on unmapped CB opcodes (CB LUT index 0).
module dzcpu_uop_sequencer #(
  parameter logic [4:0] JCB_OP = 5'h1F
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic [7:0]  iMop,
  input  logic        iMopValid,
  input  logic        iStall,
  input  logic        iZ,
  input  logic [7:0]  iFlowIdx,
  input  logic [7:0]  iCbFlowIdx,
  input  logic [11:0] iUop,
  output logic [7:0]  oMop,
  output logic [7:0]  oUopAddr,
  output logic [11:0] oUop,
  output logic        oUopValid,
  output logic        oPcInc,
  output logic        oRetire,
  output logic        oIllegal
);

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    CBDEC,
    TRAP
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  mop_q, mop_nxt;
  logic [7:0]  addr_q, addr_nxt;
  logic        uop_valid, pc_inc, retire;
  logic [2:0]  flow;
  logic [4:0]  op;

  assign flow = iUop[11:9];
  assign op   = iUop[8:4];

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      state  <= FETCH;
      mop_q  <= '0;
      addr_q <= '0;
    end else begin
      state  <= state_nxt;
      mop_q  <= mop_nxt;
      addr_q <= addr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mop_nxt   = mop_q;
    addr_nxt  = addr_q;
    uop_valid = 1'b0;
    pc_inc    = 1'b0;
    retire    = 1'b0;
    if (!iStall) begin
      unique case (state)
        FETCH: begin
          if (iMopValid) begin
            mop_nxt   = iMop;
            state_nxt = DECODE;
          end
        end
        DECODE: begin
          addr_nxt  = iFlowIdx;
          state_nxt = EXEC;
        end
        EXEC: begin
          uop_valid = 1'b1;
          unique case (1'b1)
            flow == 3'd1: pc_inc = 1'b1;
            flow == 3'd2: retire = 1'b1;
            flow == 3'd3: begin
              pc_inc = 1'b1;
              retire = 1'b1;
            end
            flow == 3'd4: begin
              pc_inc = 1'b1;
              retire = iZ;
            end
            default: ;
          endcase
          // The prefix jump overrides flow sequencing; pulses still fire.
          if (op == JCB_OP) begin
            mop_nxt   = iMop;
            state_nxt = CBDEC;
          end else if (retire) begin
            state_nxt = FETCH;
          end else begin
            addr_nxt = addr_q + 8'd1;
          end
        end
        CBDEC: begin
`ifdef DZCPU_CB_TRAP_EN
          if (iCbFlowIdx == 8'd0) begin
            state_nxt = TRAP;
          end else begin
            addr_nxt  = iCbFlowIdx;
            state_nxt = EXEC;
          end
`else
          addr_nxt  = iCbFlowIdx;
          state_nxt = EXEC;
`endif
        end
        TRAP: state_nxt = TRAP;
        default: state_nxt = FETCH;
      endcase
    end
  end

  assign oMop      = mop_q;
  assign oUopAddr  = addr_q;
  assign oUop      = iUop;
  assign oUopValid = uop_valid;
  assign oPcInc    = pc_inc;
  assign oRetire   = retire;
`ifdef DZCPU_CB_TRAP_EN
  assign oIllegal  = (state == TRAP);
`else
  assign oIllegal  = 1'b0;
`endif

endmodule

// File: tb/tb_dzcpu_uop_sequencer.sv
// Scoreboard bench for dzcpu_uop_sequencer: directed opcodes against a bench ROM/LUT.
// Expected uops are queued at issue; a negedge monitor pops and compares.
module tb_dzcpu_uop_sequencer;

  localparam logic [4:0] JCB = 5'h1F;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  mop_in = 8'h00;
  logic        mop_valid = 1'b0;
  logic        stall = 1'b0;
  logic        z = 1'b0;
  logic [7:0]  flow_idx, cb_idx;
  logic [11:0] uop_in;
  logic [7:0]  mop_out, uop_addr;
  logic [11:0] uop_out;
  logic        uop_valid, pc_inc, retire, illegal;

  logic [11:0] rom [256];

  typedef struct {
    logic [7:0]  addr;
    logic [11:0] uop;
    logic        pc;
    logic        ret;
    int          at;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   c0;

  function automatic logic [7:0] main_lut(input logic [7:0] m);
    case (m)
      8'h31:   return 8'd1;
      8'hCB:   return 8'd13;
      8'h40:   return 8'd19;
      8'h50:   return 8'd5;
      8'hFF:   return 8'd255;
      default: return 8'd0;
    endcase
  endfunction

  function automatic logic [7:0] cb_lut(input logic [7:0] m);
    if (m == 8'h7C) return 8'd16;
    return 8'd0;
  endfunction

  assign uop_in   = rom[uop_addr];
  assign flow_idx = main_lut(mop_out);
  assign cb_idx   = cb_lut(mop_out);

  dzcpu_uop_sequencer #(.JCB_OP(JCB)) dut (
    .iClock     (clk),
    .iReset     (rst_n),
    .iMop       (mop_in),
    .iMopValid  (mop_valid),
    .iStall     (stall),
    .iZ         (z),
    .iFlowIdx   (flow_idx),
    .iCbFlowIdx (cb_idx),
    .iUop       (uop_in),
    .oMop       (mop_out),
    .oUopAddr   (uop_addr),
    .oUop       (uop_out),
    .oUopValid  (uop_valid),
    .oPcInc     (pc_inc),
    .oRetire    (retire),
    .oIllegal   (illegal)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every valid uop must match the head of the queue.
  always @(negedge clk) begin
    if (uop_valid) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_uop addr=%0d uop=%h", uop_addr, uop_out);
      end else begin
        mon_e = q.pop_front();
        if ({uop_addr, uop_out, pc_inc, retire} !==
            {mon_e.addr, mon_e.uop, mon_e.pc, mon_e.ret}) begin
          failures++;
          $display("FAIL uop got addr=%0d uop=%h pc=%b ret=%b want addr=%0d uop=%h pc=%b ret=%b",
                   uop_addr, uop_out, pc_inc, retire,
                   mon_e.addr, mon_e.uop, mon_e.pc, mon_e.ret);
        end
        if (mon_e.at >= 0) begin
          checks++;
          if (cyc != mon_e.at) begin
            failures++;
            $display("FAIL latency got cycle=%0d want cycle=%0d", cyc, mon_e.at);
          end
        end
      end
    end else begin
      checks++;
      if ({pc_inc, retire} !== 2'b00) begin
        failures++;
        $display("FAIL pulse_no_valid got pc=%b ret=%b want 00", pc_inc, retire);
      end
    end
  end

  task automatic push(input logic [7:0] a, input logic pc, input logic ret, input int at);
    exp_t e;
    e.addr = a;
    e.uop  = rom[a];
    e.pc   = pc;
    e.ret  = ret;
    e.at   = at;
    q.push_back(e);
  endtask

  // Called at posedge+1; the next edge samples the opcode.
  task automatic issue(input logic [7:0] op, output int c);
    c = cyc;
    mop_in = op;
    mop_valid = 1'b1;
    @(posedge clk);
    #1;
    mop_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout got pending=%0d want 0", q.size());
      q.delete();
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 12'h000;
    rom[0]   = 12'h600;
    rom[1]   = 12'h200;
    rom[2]   = 12'h201;
    rom[3]   = 12'h005;
    rom[4]   = 12'h600;
    rom[5]   = 12'h011;
    rom[6]   = 12'h012;
    rom[7]   = 12'h013;
    rom[8]   = 12'h400;
    rom[13]  = 12'h200;
    rom[14]  = 12'h023;
    rom[15]  = {3'd1, JCB, 4'h0};
    rom[16]  = 12'h400;
    rom[19]  = 12'h800;
    rom[20]  = 12'h400;
    rom[255] = 12'h0A1;

    #2;
    check("reset_outputs",
          {8'h0, mop_out, uop_addr, uop_valid, pc_inc, retire, illegal, 4'h0},
          32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    issue(8'h00, c0);
    push(8'd0, 1'b1, 1'b1, c0 + 2);
    drain();

    issue(8'h31, c0);
    push(8'd1, 1'b1, 1'b0, -1);
    push(8'd2, 1'b1, 1'b0, -1);
    push(8'd3, 1'b0, 1'b0, -1);
    push(8'd4, 1'b1, 1'b1, -1);
    drain();
    check("mop_31", {24'h0, mop_out}, 32'h31);

    issue(8'hCB, c0);
    mop_in = 8'h7C;
    push(8'd13, 1'b1, 1'b0, -1);
    push(8'd14, 1'b0, 1'b0, -1);
    push(8'd15, 1'b1, 1'b0, -1);
    push(8'd16, 1'b0, 1'b1, -1);
    drain();
    check("mop_cb_7c", {24'h0, mop_out}, 32'h7C);

    z = 1'b1;
    issue(8'h40, c0);
    push(8'd19, 1'b1, 1'b1, -1);
    drain();
    z = 1'b0;
    issue(8'h40, c0);
    push(8'd19, 1'b1, 1'b0, -1);
    push(8'd20, 1'b0, 1'b1, -1);
    drain();

    issue(8'hFF, c0);
    push(8'd255, 1'b0, 1'b0, -1);
    push(8'd0, 1'b1, 1'b1, -1);
    drain();

    issue(8'h50, c0);
    push(8'd5, 1'b0, 1'b0, -1);
    push(8'd6, 1'b0, 1'b0, -1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stall_hold", {20'h0, uop_addr, 1'b0, uop_valid, pc_inc, retire},
            {20'h0, 8'd6, 4'b0000});
      @(posedge clk);
    end
    #1;
    stall = 1'b0;
    @(posedge clk);
    #1;
    check("addr_before_reset", {24'h0, uop_addr}, 32'd7);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {8'h0, mop_out, uop_addr, uop_valid, pc_inc, retire, illegal, 4'h0},
          32'h0);
    check("no_pending_after_reset", q.size(), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(8'h00, c0);
    push(8'd0, 1'b1, 1'b1, c0 + 2);
    drain();

    issue(8'hCB, c0);
    mop_in = 8'h00;
    push(8'd13, 1'b1, 1'b0, -1);
    push(8'd14, 1'b0, 1'b0, -1);
    push(8'd15, 1'b1, 1'b0, -1);
`ifdef DZCPU_CB_TRAP_EN
    drain();
    repeat (3) @(posedge clk);
    #1;
    check("trap_illegal", {30'h0, illegal, uop_valid}, 32'b10);
    repeat (5) @(posedge clk);
    #1;
    check("trap_hold", {30'h0, illegal, uop_valid}, 32'b10);
    rst_n = 1'b0;
    #1;
    check("trap_reset", {31'h0, illegal}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`else
    push(8'd0, 1'b1, 1'b1, -1);
    drain();
    check("no_trap_illegal", {31'h0, illegal}, 32'd0);
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
